// File: rtl/lcd_wr_if.sv
// Byte-write handshake between the text/message logic and the LCD sequencer.
interface lcd_wr_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_ctrl_seq.sv
// HD44780-style 8-bit LCD sequencer: power-up wait, fixed init ROM, then one
// handshaked byte at a time with RS setup, E pulse and post-write wait.
module lcd_ctrl_seq #(
  parameter int unsigned PWRUP_CYC    = 1_000_000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_HIGH_CYC   = 12,
  parameter int unsigned CMD_WAIT_CYC = 2_500,
  parameter int unsigned CLR_WAIT_CYC = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_wr_if.slave      wr,
  output logic         init_done,
  output logic         busy,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e
);

  localparam int unsigned MaxA   = (PWRUP_CYC > SETUP_CYC) ? PWRUP_CYC : SETUP_CYC;
  localparam int unsigned MaxB   = (E_HIGH_CYC > CMD_WAIT_CYC) ? E_HIGH_CYC : CMD_WAIT_CYC;
  localparam int unsigned MaxC   = (MaxB > CLR_WAIT_CYC) ? MaxB : CLR_WAIT_CYC;
  localparam int unsigned MaxCyc = (MaxA > MaxC) ? MaxA : MaxC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam logic [2:0]  RomLast = 3'd5;

  typedef enum logic [2:0] {StPwrup, StSetup, StEHigh, StWait, StIdle} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              long_q, long_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d;
  logic              e_q, e_d;
  logic              ready_q, ready_d;
  logic              init_done_q, init_done_d;

  function automatic logic [7:0] rom_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h0C;
      3'd4:             rom_byte = 8'h01;
      default:          rom_byte = 8'h06;
    endcase
  endfunction

  // Function set (first) and clear display need the long execution wait.
  function automatic logic rom_long(input logic [2:0] i);
    rom_long = (i == 3'd0) || (i == 3'd4);
  endfunction

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    long_d      = long_q;
    data_d      = data_q;
    rs_d        = rs_q;
    e_d         = e_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StPwrup: begin
        if (cnt_q == '0) begin
          state_d = StSetup;
          idx_d   = 3'd0;
          data_d  = rom_byte(3'd0);
          rs_d    = 1'b0;
          long_d  = rom_long(3'd0);
          cnt_d   = CntW'(SETUP_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StEHigh;
          e_d     = 1'b1;
          cnt_d   = CntW'(E_HIGH_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEHigh: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          e_d     = 1'b0;
          cnt_d   = long_q ? CntW'(CLR_WAIT_CYC - 1) : CntW'(CMD_WAIT_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (!init_done_q && (idx_q != RomLast)) begin
            state_d = StSetup;
            idx_d   = idx_q + 3'd1;
            data_d  = rom_byte(idx_q + 3'd1);
            rs_d    = 1'b0;
            long_d  = rom_long(idx_q + 3'd1);
            cnt_d   = CntW'(SETUP_CYC - 1);
          end else begin
            state_d     = StIdle;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StIdle: begin
        if (ready_q && wr.wr_valid) begin
          state_d = StSetup;
          data_d  = wr.wr_data;
          rs_d    = wr.wr_rs;
          // Clear display / return home are the slow commands.
          long_d  = !wr.wr_rs && ((wr.wr_data == 8'h01) || (wr.wr_data == 8'h02));
          cnt_d   = CntW'(SETUP_CYC - 1);
          ready_d = 1'b0;
        end
      end
      default: state_d = StPwrup;
    endcase
  end

  // State and output registers; counter preloaded with the power-up length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPwrup;
      cnt_q       <= CntW'(PWRUP_CYC - 1);
      idx_q       <= 3'd0;
      long_q      <= 1'b0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      long_q      <= long_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      e_q         <= e_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign wr.wr_ready = ready_q;
  assign init_done   = init_done_q;
  assign busy        = (state_q != StIdle);
  assign lcd_data    = data_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = 1'b0;
  assign lcd_e       = e_q;

endmodule
